// File: rtl/video_timing_pkg.sv
// Shared video timing types: supported modes, sequencer states, the ten-field
// N-1 encoded timing set and the per-mode timing rows.
package video_timing_pkg;

  localparam int TIMING_W = 12;

  typedef enum logic [1:0] {
    MODE_640x480  = 2'd0,
    MODE_800x600  = 2'd1,
    MODE_1280x720 = 2'd2
  } video_mode_e;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_HOLD       = 2'd2,
    ST_BLANKING   = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic [TIMING_W-1:0] h_active;
    logic [TIMING_W-1:0] h_front_porch;
    logic [TIMING_W-1:0] h_sync_length;
    logic [TIMING_W-1:0] h_back_porch;
    logic [TIMING_W-1:0] h_total;
    logic [TIMING_W-1:0] v_active;
    logic [TIMING_W-1:0] v_front_porch;
    logic [TIMING_W-1:0] v_sync_length;
    logic [TIMING_W-1:0] v_back_porch;
    logic [TIMING_W-1:0] v_total;
  } timing_set_t;

  localparam timing_set_t TIMING_640x480 = '{
    12'd639,  12'd15,  12'd95,  12'd47,  12'd799,
    12'd479,  12'd9,   12'd1,   12'd32,  12'd524
  };

  localparam timing_set_t TIMING_800x600 = '{
    12'd799,  12'd39,  12'd127, 12'd87,  12'd1055,
    12'd599,  12'd0,   12'd3,   12'd22,  12'd627
  };

  localparam timing_set_t TIMING_1280x720 = '{
    12'd1279, 12'd109, 12'd39,  12'd219, 12'd1649,
    12'd719,  12'd4,   12'd4,   12'd19,  12'd749
  };

  // Reset-time lookup; the illegal code falls back to the 640x480 row.
  function automatic timing_set_t mode_timing(input logic [1:0] sel);
    timing_set_t t;
    case (sel)
      2'd0:    t = TIMING_640x480;
      2'd1:    t = TIMING_800x600;
      2'd2:    t = TIMING_1280x720;
      default: t = TIMING_640x480;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/video_mode_sequencer_if.sv
// Control and timing-generator facing signals of the video mode sequencer.
// The sequencer uses the slave modport; the controlling side uses master.
interface video_mode_sequencer_if;
  import video_timing_pkg::*;

  logic                mode_req_valid;
  logic [1:0]          mode_req_sel;
  logic                mode_req_ready;
  logic                frame_start;
  logic                timing_enable;
  logic                blank;
  logic [1:0]          mode_active;
  logic                mode_locked;
  logic                err_bad_mode;
  logic [TIMING_W-1:0] h_active;
  logic [TIMING_W-1:0] h_front_porch;
  logic [TIMING_W-1:0] h_sync_length;
  logic [TIMING_W-1:0] h_back_porch;
  logic [TIMING_W-1:0] h_total;
  logic [TIMING_W-1:0] v_active;
  logic [TIMING_W-1:0] v_front_porch;
  logic [TIMING_W-1:0] v_sync_length;
  logic [TIMING_W-1:0] v_back_porch;
  logic [TIMING_W-1:0] v_total;

  modport master (
    output mode_req_valid, mode_req_sel, frame_start,
    input  mode_req_ready, timing_enable, blank, mode_active, mode_locked, err_bad_mode,
    input  h_active, h_front_porch, h_sync_length, h_back_porch, h_total,
    input  v_active, v_front_porch, v_sync_length, v_back_porch, v_total
  );

  modport slave (
    input  mode_req_valid, mode_req_sel, frame_start,
    output mode_req_ready, timing_enable, blank, mode_active, mode_locked, err_bad_mode,
    output h_active, h_front_porch, h_sync_length, h_back_porch, h_total,
    output v_active, v_front_porch, v_sync_length, v_back_porch, v_total
  );

endinterface

// File: rtl/video_mode_rom.sv
// Combinational mode table: maps a 2-bit mode select to its timing set and
// flags whether the select names a supported mode.
module video_mode_rom
  import video_timing_pkg::*;
(
  input  logic [1:0]  sel,
  output timing_set_t timing,
  output logic        legal
);

  // Table lookup; code 3 is reported illegal and returns a harmless row.
  always_comb begin
    timing = TIMING_640x480;
    legal  = 1'b0;
    case (sel)
      2'd0: begin
        timing = TIMING_640x480;
        legal  = 1'b1;
      end
      2'd1: begin
        timing = TIMING_800x600;
        legal  = 1'b1;
      end
      2'd2: begin
        timing = TIMING_1280x720;
        legal  = 1'b1;
      end
      default: begin
        timing = TIMING_640x480;
        legal  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/video_mode_sequencer.sv
// Sequences video mode changes: wait for a frame boundary, freeze the timing
// generator while the new timing set loads, then blank for a few frames.
module video_mode_sequencer
  import video_timing_pkg::*;
#(
  parameter int DEFAULT_MODE  = 0,
  parameter int SETTLE_CYCLES = 16,
  parameter int BLANK_FRAMES  = 2,
  parameter int FRAME_TIMEOUT = 2097151
) (
  input logic                   pixel_clock,
  input logic                   reset,
  video_mode_sequencer_if.slave vif
);

  localparam logic [1:0]  DEF_MODE    = 2'(DEFAULT_MODE);
  localparam timing_set_t DEF_TIMING  = mode_timing(DEF_MODE);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] FRAMES_LAST = 16'(BLANK_FRAMES - 1);
  localparam logic [20:0] TMO_LAST    = 21'(FRAME_TIMEOUT - 1);

  seq_state_e  state, next_state;
  logic [1:0]  pending, pending_next;
  logic [1:0]  active_mode, active_mode_next;
  timing_set_t timing, timing_next;
  logic [20:0] tmo_cnt, tmo_cnt_next;
  logic [15:0] settle_cnt, settle_cnt_next;
  logic [15:0] frame_cnt, frame_cnt_next;
  logic        err_next;

  logic        req_ready;
  logic        enable;
  logic        blank;
  logic        locked;
  logic        err_bad;

  logic [1:0]  rom_sel;
  timing_set_t rom_timing;
  logic        rom_legal;

  // In RUN the ROM validates the incoming request, otherwise it serves the pending mode.
  assign rom_sel = (state == ST_RUN) ? vif.mode_req_sel : pending;

  video_mode_rom u_rom (
    .sel    (rom_sel),
    .timing (rom_timing),
    .legal  (rom_legal)
  );

  // Next-state and next-register computation; counters restart at zero on any state change.
  always_comb begin
    next_state       = state;
    pending_next     = pending;
    active_mode_next = active_mode;
    timing_next      = timing;
    tmo_cnt_next     = 21'd0;
    settle_cnt_next  = 16'd0;
    frame_cnt_next   = 16'd0;
    err_next         = 1'b0;

    case (state)
      ST_RUN: begin
        if (vif.mode_req_valid) begin
          if (!rom_legal) begin
            err_next = 1'b1;
          end else if (vif.mode_req_sel != active_mode) begin
            pending_next = vif.mode_req_sel;
            next_state   = ST_WAIT_FRAME;
          end else begin
            next_state = ST_RUN;
          end
        end else begin
          next_state = ST_RUN;
        end
      end

      ST_WAIT_FRAME: begin
        if (vif.frame_start || (tmo_cnt == TMO_LAST)) begin
          next_state = ST_HOLD;
        end else begin
          tmo_cnt_next = tmo_cnt + 21'd1;
        end
      end

      ST_HOLD: begin
        // Load one cycle after entry, while the generator is already frozen.
        if (settle_cnt == 16'd0) begin
          active_mode_next = pending;
          timing_next      = rom_timing;
        end else begin
          active_mode_next = active_mode;
        end
        if (settle_cnt == SETTLE_LAST) begin
          next_state = ST_BLANKING;
        end else begin
          settle_cnt_next = settle_cnt + 16'd1;
        end
      end

      ST_BLANKING: begin
        if (vif.frame_start) begin
          if (frame_cnt == FRAMES_LAST) begin
            next_state = ST_RUN;
          end else begin
            frame_cnt_next = frame_cnt + 16'd1;
          end
        end else begin
          frame_cnt_next = frame_cnt;
        end
      end

      default: begin
        next_state = ST_HOLD;
      end
    endcase
  end

  // State, counters and registered outputs; outputs are decoded from next_state.
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      state       <= ST_HOLD;
      pending     <= DEF_MODE;
      active_mode <= DEF_MODE;
      timing      <= DEF_TIMING;
      tmo_cnt     <= 21'd0;
      settle_cnt  <= 16'd0;
      frame_cnt   <= 16'd0;
      req_ready   <= 1'b0;
      enable      <= 1'b0;
      blank       <= 1'b1;
      locked      <= 1'b0;
      err_bad     <= 1'b0;
    end else begin
      state       <= next_state;
      pending     <= pending_next;
      active_mode <= active_mode_next;
      timing      <= timing_next;
      tmo_cnt     <= tmo_cnt_next;
      settle_cnt  <= settle_cnt_next;
      frame_cnt   <= frame_cnt_next;
      req_ready   <= (next_state == ST_RUN);
      enable      <= (next_state != ST_HOLD);
      blank       <= (next_state != ST_RUN);
      locked      <= (next_state == ST_RUN);
      err_bad     <= err_next;
    end
  end

  assign vif.mode_req_ready = req_ready;
  assign vif.timing_enable  = enable;
  assign vif.blank          = blank;
  assign vif.mode_active    = active_mode;
  assign vif.mode_locked    = locked;
  assign vif.err_bad_mode   = err_bad;
  assign vif.h_active       = timing.h_active;
  assign vif.h_front_porch  = timing.h_front_porch;
  assign vif.h_sync_length  = timing.h_sync_length;
  assign vif.h_back_porch   = timing.h_back_porch;
  assign vif.h_total        = timing.h_total;
  assign vif.v_active       = timing.v_active;
  assign vif.v_front_porch  = timing.v_front_porch;
  assign vif.v_sync_length  = timing.v_sync_length;
  assign vif.v_back_porch   = timing.v_back_porch;
  assign vif.v_total        = timing.v_total;

endmodule

// File: tb/tb_video_mode_sequencer.sv
// Directed bench for video_mode_sequencer: a per-cycle vector table for the
// startup and switch flow, plus hand-written timeout and reset-in-HOLD runs.
module tb_video_mode_sequencer;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  video_mode_sequencer_if vif();

  video_mode_sequencer #(
    .DEFAULT_MODE  (0),
    .SETTLE_CYCLES (16),
    .BLANK_FRAMES  (2),
    .FRAME_TIMEOUT (100)
  ) u_dut (
    .pixel_clock (clk),
    .reset       (rst),
    .vif         (vif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference rows, written out independently of the design package.
  int exp_tab [0:2][0:9] = '{
    '{639, 15, 95, 47, 799, 479, 9, 1, 32, 524},
    '{799, 39, 127, 87, 1055, 599, 0, 3, 22, 627},
    '{1279, 109, 39, 219, 1649, 719, 4, 4, 19, 749}
  };

  typedef struct packed {
    logic [7:0]  reps;
    logic        valid;
    logic [1:0]  sel;
    logic        fs;
    logic        ready;
    logic        enable;
    logic        blank;
    logic        locked;
    logic        err;
    logic [1:0]  mode;
    logic [11:0] htot;
    logic [11:0] vtot;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_fs();
    vif.frame_start = 1'b1;
    tick();
    vif.frame_start = 1'b0;
  endtask

  task automatic chk_row(input string tag, input int m);
    chk({tag, ".h_active"},      32'(vif.h_active),      32'(exp_tab[m][0]));
    chk({tag, ".h_front_porch"}, 32'(vif.h_front_porch), 32'(exp_tab[m][1]));
    chk({tag, ".h_sync_length"}, 32'(vif.h_sync_length), 32'(exp_tab[m][2]));
    chk({tag, ".h_back_porch"},  32'(vif.h_back_porch),  32'(exp_tab[m][3]));
    chk({tag, ".h_total"},       32'(vif.h_total),       32'(exp_tab[m][4]));
    chk({tag, ".v_active"},      32'(vif.v_active),      32'(exp_tab[m][5]));
    chk({tag, ".v_front_porch"}, 32'(vif.v_front_porch), 32'(exp_tab[m][6]));
    chk({tag, ".v_sync_length"}, 32'(vif.v_sync_length), 32'(exp_tab[m][7]));
    chk({tag, ".v_back_porch"},  32'(vif.v_back_porch),  32'(exp_tab[m][8]));
    chk({tag, ".v_total"},       32'(vif.v_total),       32'(exp_tab[m][9]));
    chk({tag, ".mode_active"},   32'(vif.mode_active),   32'(m));
  endtask

  task automatic chk_ctl(input string tag, input logic ready, input logic en,
                         input logic blank, input logic locked);
    chk({tag, ".ready"},  32'(vif.mode_req_ready), 32'(ready));
    chk({tag, ".enable"}, 32'(vif.timing_enable),  32'(en));
    chk({tag, ".blank"},  32'(vif.blank),          32'(blank));
    chk({tag, ".locked"}, 32'(vif.mode_locked),    32'(locked));
  endtask

  function automatic void add(input int reps, input logic v, input logic [1:0] s, input logic f,
                              input logic rdy, input logic en, input logic bl, input logic lk,
                              input logic er, input logic [1:0] m, input int ht, input int vt);
    vec_t e;
    e = '{8'(reps), v, s, f, rdy, en, bl, lk, er, m, 12'(ht), 12'(vt)};
    vecs.push_back(e);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    vif.mode_req_valid = 1'b0;
    vif.mode_req_sel   = 2'd0;
    vif.frame_start    = 1'b0;

    // Startup restart, then a full switch to 1280x720 with ignored inputs sprinkled in.
    add(15, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 799, 524);
    add(1,  1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 799, 524);
    add(1,  1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 799, 524);
    add(2,  1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 799, 524);
    add(1,  1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 799, 524);
    add(1,  1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 799, 524);
    add(1,  1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 799, 524);
    add(1,  1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 799, 524);
    add(3,  1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 799, 524);
    add(1,  1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 799, 524);
    add(1,  1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1649, 749);
    add(14, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1649, 749);
    add(1,  1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 1649, 749);
    add(1,  1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 1649, 749);
    add(1,  1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 1649, 749);
    // Illegal select pulses the error; a request for the current mode is a no-op.
    add(1,  1'b1, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 1649, 749);
    add(1,  1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 1649, 749);
    add(1,  1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 1649, 749);
    add(2,  1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 1649, 749);

    @(negedge clk);
    chk_ctl("reset", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("reset.err", 32'(vif.err_bad_mode), 32'd0);
    chk_row("reset", 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      for (int r = 0; r < int'(vecs[i].reps); r++) begin
        vif.mode_req_valid = vecs[i].valid;
        vif.mode_req_sel   = vecs[i].sel;
        vif.frame_start    = vecs[i].fs;
        tick();
        chk($sformatf("v%0d.%0d.ready", i, r),  32'(vif.mode_req_ready), 32'(vecs[i].ready));
        chk($sformatf("v%0d.%0d.enable", i, r), 32'(vif.timing_enable),  32'(vecs[i].enable));
        chk($sformatf("v%0d.%0d.blank", i, r),  32'(vif.blank),          32'(vecs[i].blank));
        chk($sformatf("v%0d.%0d.locked", i, r), 32'(vif.mode_locked),    32'(vecs[i].locked));
        chk($sformatf("v%0d.%0d.err", i, r),    32'(vif.err_bad_mode),   32'(vecs[i].err));
        chk($sformatf("v%0d.%0d.mode", i, r),   32'(vif.mode_active),    32'(vecs[i].mode));
        chk($sformatf("v%0d.%0d.h_total", i, r), 32'(vif.h_total),       32'(vecs[i].htot));
        chk($sformatf("v%0d.%0d.v_total", i, r), 32'(vif.v_total),       32'(vecs[i].vtot));
      end
    end
    vif.mode_req_valid = 1'b0;
    vif.frame_start    = 1'b0;
    chk_row("run_mode2", 2);

    // No frame_start after a request for 800x600: the timeout forces HOLD after 100 clocks.
    vif.mode_req_valid = 1'b1;
    vif.mode_req_sel   = 2'd1;
    tick();
    vif.mode_req_valid = 1'b0;
    chk_ctl("tmo_accept", 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (99) tick();
    chk_ctl("tmo_99", 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    chk_ctl("tmo_100", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("tmo_100.mode", 32'(vif.mode_active), 32'd2);
    tick();
    chk_row("tmo_load", 1);
    repeat (14) tick();
    chk("tmo_hold_end.enable", 32'(vif.timing_enable), 32'd0);
    tick();
    chk_ctl("tmo_blanking", 1'b0, 1'b1, 1'b1, 1'b0);
    pulse_fs();
    pulse_fs();
    chk_ctl("tmo_run", 1'b1, 1'b1, 1'b0, 1'b1);
    chk_row("tmo_run", 1);

    // Reset arriving in HOLD of a switch to 1280x720 drops back to the default mode.
    vif.mode_req_valid = 1'b1;
    vif.mode_req_sel   = 2'd2;
    tick();
    vif.mode_req_valid = 1'b0;
    pulse_fs();
    tick();
    chk_row("rst_hold_pre", 2);
    #2;
    rst = 1'b1;
    #1;
    chk_ctl("rst_async", 1'b0, 1'b0, 1'b1, 1'b0);
    chk_row("rst_async", 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (15) tick();
    chk_ctl("rst_settle", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("rst_settle.mode", 32'(vif.mode_active), 32'd0);
    tick();
    chk_ctl("rst_blanking", 1'b0, 1'b1, 1'b1, 1'b0);
    pulse_fs();
    chk_ctl("rst_one_frame", 1'b0, 1'b1, 1'b1, 1'b0);
    pulse_fs();
    chk_ctl("rst_run", 1'b1, 1'b1, 1'b0, 1'b1);
    chk_row("rst_run", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
